// File: rtl/ball_engine_if.sv
// Control and position bus between the game logic (master) and the ball engine (slave).
interface ball_engine_if;
  logic       tick;
  logic       pause;
  logic [9:0] bar_1_y;
  logic [9:0] bar_2_y;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic       point1;
  logic       point2;
  logic       serving;

  modport master (
    output tick, pause, bar_1_y, bar_2_y,
    input  x_ball, y_ball, point1, point2, serving
  );

  modport slave (
    input  tick, pause, bar_1_y, bar_2_y,
    output x_ball, y_ball, point1, point2, serving
  );
endinterface

// File: rtl/ball_engine.sv
// Pong ball engine: serve / play / score FSM with wall and paddle reflection.
// Define BALL_SPEEDUP_EN to speed the ball up on every paddle hit (1..4); otherwise speed is fixed at 2.
module ball_engine #(
  parameter int FIELD_W     = 620,
  parameter int FIELD_H     = 360,
  parameter int BALL_R      = 4,
  parameter int BAR1_X      = 20,
  parameter int BAR2_X      = 600,
  parameter int BAR_HW      = 5,
  parameter int BAR_HH      = 30,
  parameter int SERVE_TICKS = 64
) (
  input  logic         mclk,
  input  logic         reset_n,
  ball_engine_if.slave bus
);

  typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_t;

  localparam int                    CNT_W      = $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(SERVE_TICKS - 1);
  localparam logic [9:0]            X_CENTRE   = 10'(FIELD_W / 2);
  localparam logic [9:0]            Y_CENTRE   = 10'(FIELD_H / 2);
  localparam logic [9:0]            Y_LO       = 10'(BALL_R);
  localparam logic [9:0]            Y_HI       = 10'(FIELD_H - BALL_R);
  localparam logic [9:0]            LEFT_REST  = 10'(BAR1_X + BAR_HW + BALL_R);
  localparam logic [9:0]            RIGHT_REST = 10'(BAR2_X - BAR_HW - BALL_R);
  localparam logic signed [10:0]    R_S        = 11'(BALL_R);
  localparam logic signed [10:0]    Y_MIN      = 11'(BALL_R);
  localparam logic signed [10:0]    Y_MAX      = 11'(FIELD_H - BALL_R);
  localparam logic signed [10:0]    X_MIN      = 11'(BALL_R);
  localparam logic signed [10:0]    X_MAX      = 11'(FIELD_W - BALL_R);
  localparam logic signed [10:0]    LEFT_FACE  = 11'(BAR1_X + BAR_HW);
  localparam logic signed [10:0]    RIGHT_FACE = 11'(BAR2_X - BAR_HW);
  localparam logic signed [10:0]    LEFT_X     = 11'(BAR1_X);
  localparam logic signed [10:0]    RIGHT_X    = 11'(BAR2_X);
  localparam logic signed [10:0]    REACH      = 11'(BAR_HH + BALL_R);

`ifdef BALL_SPEEDUP_EN
  localparam logic [2:0] SPEED_INIT = 3'd1;
  localparam logic [2:0] SPEED_MAX  = 3'd4;
`else
  localparam logic [2:0] SPEED_INIT = 3'd2;
  localparam logic [2:0] SPEED_MAX  = 3'd2;
`endif

  state_t            state;
  logic [9:0]        x_q, y_q;
  logic              dx_pos, dy_pos;
  logic [2:0]        speed;
  logic [CNT_W-1:0]  serve_cnt;
  logic              point1_q, point2_q, serving_q;

  logic              step;
  logic signed [10:0] x_cur, y_cur, speed_s, x_next, y_next;
  logic signed [10:0] dist_1, dist_2, abs_1, abs_2;
  logic [9:0]        y_wall;
  logic              dy_wall;
  logic              hit_1, hit_2, miss_1, miss_2;

  assign step    = bus.tick && !bus.pause;
  assign x_cur   = signed'({1'b0, x_q});
  assign y_cur   = signed'({1'b0, y_q});
  assign speed_s = signed'({8'd0, speed});
  assign x_next  = dx_pos ? x_cur + speed_s : x_cur - speed_s;
  assign y_next  = dy_pos ? y_cur + speed_s : y_cur - speed_s;

  // Wall reflection acts on y only; paddle reflection acts on x only, so both can apply at once.
  assign y_wall  = (y_next <= Y_MIN) ? Y_LO : (y_next >= Y_MAX) ? Y_HI : y_next[9:0];
  assign dy_wall = (y_next <= Y_MIN) ? 1'b1 : (y_next >= Y_MAX) ? 1'b0 : dy_pos;

  assign dist_1  = y_next - signed'({1'b0, bus.bar_1_y});
  assign dist_2  = y_next - signed'({1'b0, bus.bar_2_y});
  assign abs_1   = dist_1[10] ? -dist_1 : dist_1;
  assign abs_2   = dist_2[10] ? -dist_2 : dist_2;

  assign hit_1   = !dx_pos && (x_next - R_S <= LEFT_FACE) && (x_cur >= LEFT_X) && (abs_1 <= REACH);
  assign hit_2   = dx_pos && (x_next + R_S >= RIGHT_FACE) && (x_cur <= RIGHT_X) && (abs_2 <= REACH);
  assign miss_1  = dx_pos && !hit_2 && (x_next >= X_MAX);
  assign miss_2  = !dx_pos && !hit_1 && (x_next <= X_MIN);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SERVE;
      x_q       <= X_CENTRE;
      y_q       <= Y_CENTRE;
      dx_pos    <= 1'b1;
      dy_pos    <= 1'b1;
      speed     <= SPEED_INIT;
      serve_cnt <= '0;
      point1_q  <= 1'b0;
      point2_q  <= 1'b0;
      serving_q <= 1'b1;
    end else begin
      point1_q <= 1'b0;
      point2_q <= 1'b0;
      if (step) begin
        case (state)
          SERVE: begin
            if (serve_cnt == CNT_LAST) begin
              state     <= PLAY;
              serve_cnt <= '0;
              serving_q <= 1'b0;
            end else begin
              serve_cnt <= serve_cnt + CNT_W'(1);
            end
          end
          PLAY: begin
            // A miss freezes the ball where it last was inside the field.
            if (miss_1) begin
              point1_q <= 1'b1;
              state    <= SCORED;
            end else if (miss_2) begin
              point2_q <= 1'b1;
              state    <= SCORED;
            end else begin
              y_q    <= y_wall;
              dy_pos <= dy_wall;
              if (hit_1 || hit_2) begin
                x_q    <= hit_1 ? LEFT_REST : RIGHT_REST;
                dx_pos <= hit_1;
                if (speed < SPEED_MAX) speed <= speed + 3'd1;
              end else begin
                x_q <= x_next[9:0];
              end
            end
          end
          SCORED: begin
            // The scoring step left dx pointing at the conceding side; serve back the other way.
            state     <= SERVE;
            x_q       <= X_CENTRE;
            y_q       <= Y_CENTRE;
            speed     <= SPEED_INIT;
            dx_pos    <= !dx_pos;
            serve_cnt <= '0;
            serving_q <= 1'b1;
          end
          default: begin
            state     <= SERVE;
            serving_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.x_ball  = x_q;
  assign bus.y_ball  = y_q;
  assign bus.point1  = point1_q;
  assign bus.point2  = point2_q;
  assign bus.serving = serving_q;

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: a reference model predicts every step, paddles track or dodge the ball.
module tb_ball_engine;

  localparam int FIELD_W     = 620;
  localparam int FIELD_H     = 360;
  localparam int BALL_R      = 4;
  localparam int BAR1_X      = 20;
  localparam int BAR2_X      = 600;
  localparam int BAR_HW      = 5;
  localparam int BAR_HH      = 30;
  localparam int SERVE_TICKS = 64;

`ifdef BALL_SPEEDUP_EN
  localparam int SPD_INIT = 1;
  localparam int SPD_MAX  = 4;
  localparam int SPD_HIT1 = 2;
  localparam int SPD_HIT2 = 3;
`else
  localparam int SPD_INIT = 2;
  localparam int SPD_MAX  = 2;
  localparam int SPD_HIT1 = 2;
  localparam int SPD_HIT2 = 2;
`endif

  typedef enum int {M_SERVE, M_PLAY, M_SCORED} mstate_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       p1;
    logic       p2;
    logic       srv;
  } obs_t;

  logic mclk;
  logic reset_n;
  ball_engine_if bus();

  ball_engine dut (
    .mclk    (mclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int      errors = 0;
  int      checks = 0;
  obs_t    sb[$];
  mstate_t mstate;
  int      mx, my, mdx, mdy, mspeed, mcnt;
  bit      mp1, mp2;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    mstate = M_SERVE;
    mx = FIELD_W / 2;
    my = FIELD_H / 2;
    mdx = 1;
    mdy = 1;
    mspeed = SPD_INIT;
    mcnt = 0;
    mp1 = 0;
    mp2 = 0;
  endtask

  task automatic model_step(input int bar1, input int bar2);
    int xs, ys, ny, ndy;
    bit h1, h2;
    mp1 = 0;
    mp2 = 0;
    case (mstate)
      M_SERVE: begin
        if (mcnt == SERVE_TICKS - 1) begin
          mstate = M_PLAY;
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      M_PLAY: begin
        xs = mx + mdx * mspeed;
        ys = my + mdy * mspeed;
        ny = ys;
        ndy = mdy;
        if (ys <= BALL_R) begin
          ny = BALL_R;
          ndy = 1;
        end else if (ys >= FIELD_H - BALL_R) begin
          ny = FIELD_H - BALL_R;
          ndy = -1;
        end
        h1 = (mdx < 0) && (xs - BALL_R <= BAR1_X + BAR_HW) && (mx >= BAR1_X) && (iabs(ys - bar1) <= BAR_HH + BALL_R);
        h2 = (mdx > 0) && (xs + BALL_R >= BAR2_X - BAR_HW) && (mx <= BAR2_X) && (iabs(ys - bar2) <= BAR_HH + BALL_R);
        if (h1 || h2) begin
          mx = h1 ? BAR1_X + BAR_HW + BALL_R : BAR2_X - BAR_HW - BALL_R;
          mdx = h1 ? 1 : -1;
          my = ny;
          mdy = ndy;
          if (mspeed < SPD_MAX) mspeed++;
        end else if (mdx < 0 && xs <= BALL_R) begin
          mp2 = 1;
          mstate = M_SCORED;
        end else if (mdx > 0 && xs >= FIELD_W - BALL_R) begin
          mp1 = 1;
          mstate = M_SCORED;
        end else begin
          mx = xs;
          my = ny;
          mdy = ndy;
        end
      end
      default: begin
        mstate = M_SERVE;
        mx = FIELD_W / 2;
        my = FIELD_H / 2;
        mspeed = SPD_INIT;
        mdx = -mdx;
        mcnt = 0;
      end
    endcase
  endtask

  // Drives one cycle of tick/pause and queues what the model says the outputs must be afterwards.
  task automatic applyStimulus(input bit tck, input bit pse);
    obs_t e;
    @(negedge mclk);
    bus.tick  = tck;
    bus.pause = pse;
    if (tck && !pse) begin
      model_step(int'(bus.bar_1_y), int'(bus.bar_2_y));
    end else begin
      mp1 = 0;
      mp2 = 0;
    end
    e.x = 10'(mx);
    e.y = 10'(my);
    e.p1 = mp1;
    e.p2 = mp2;
    e.srv = (mstate == M_SERVE);
    sb.push_back(e);
    @(posedge mclk);
    #1;
    bus.tick = 1'b0;
  endtask

  always @(posedge mclk) begin
    obs_t e, a;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = {bus.x_ball, bus.y_ball, bus.point1, bus.point2, bus.serving};
      checks++;
      if (a !== e) begin
        errors++;
        $display("[TB] FAIL scoreboard: got x=%0d y=%0d p1=%0b p2=%0b serving=%0b, expected x=%0d y=%0d p1=%0b p2=%0b serving=%0b",
                 a.x, a.y, a.p1, a.p2, a.srv, e.x, e.y, e.p1, e.p2, e.srv);
      end
    end
  end

  task automatic test_reset();
    @(negedge mclk);
    bus.tick = 1'b0;
    bus.pause = 1'b0;
    bus.bar_1_y = 10'd180;
    bus.bar_2_y = 10'd180;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.x_ball, bus.y_ball} !== {10'd310, 10'd180}) begin
      errors++;
      $display("[TB] FAIL reset_pos: got (%0d,%0d) expected (310,180)", bus.x_ball, bus.y_ball);
    end
    checks++;
    if ({bus.serving, bus.point1, bus.point2} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_flags: got serving/p1/p2=%b expected 100", {bus.serving, bus.point1, bus.point2});
    end
    @(negedge mclk);
    reset_n = 1'b1;
  endtask

  task automatic test_serve();
    for (int i = 1; i <= SERVE_TICKS; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (i == SERVE_TICKS - 1) begin
        checks++;
        if (bus.serving !== 1'b1) begin
          errors++;
          $display("[TB] FAIL serve_hold: got serving=%b expected 1 after step %0d", bus.serving, i);
        end
      end
    end
    checks++;
    if ({bus.serving, bus.x_ball, bus.y_ball} !== {1'b0, 10'd310, 10'd180}) begin
      errors++;
      $display("[TB] FAIL serve_launch: got serving=%b (%0d,%0d) expected 0 (310,180)", bus.serving, bus.x_ball, bus.y_ball);
    end
    applyStimulus(1'b1, 1'b0);
    checks++;
    if ({bus.x_ball, bus.y_ball} !== {10'(310 + SPD_INIT), 10'(180 + SPD_INIT)}) begin
      errors++;
      $display("[TB] FAIL first_move: got (%0d,%0d) expected (%0d,%0d)", bus.x_ball, bus.y_ball, 310 + SPD_INIT, 180 + SPD_INIT);
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
    checks++;
    if ({bus.x_ball, bus.y_ball} !== {10'(310 + SPD_INIT), 10'(180 + SPD_INIT)}) begin
      errors++;
      $display("[TB] FAIL pause_hold: got (%0d,%0d) expected (%0d,%0d)", bus.x_ball, bus.y_ball, 310 + SPD_INIT, 180 + SPD_INIT);
    end
    applyStimulus(1'b1, 1'b0);
    checks++;
    if ({bus.x_ball, bus.y_ball} !== {10'(310 + 2 * SPD_INIT), 10'(180 + 2 * SPD_INIT)}) begin
      errors++;
      $display("[TB] FAIL pause_resume: got (%0d,%0d) expected (%0d,%0d)", bus.x_ball, bus.y_ball, 310 + 2 * SPD_INIT, 180 + 2 * SPD_INIT);
    end
  endtask

  task automatic test_wall();
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      bus.bar_1_y = 10'(my);
      bus.bar_2_y = 10'(my);
      applyStimulus(1'b1, 1'b0);
      if (bus.y_ball == 10'(FIELD_H - BALL_R)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL wall_bottom: got no y=%0d within budget, required bounce", FIELD_H - BALL_R);
    end
    applyStimulus(1'b1, 1'b0);
    checks++;
    if (bus.y_ball !== 10'(FIELD_H - BALL_R - SPD_INIT)) begin
      errors++;
      $display("[TB] FAIL wall_rebound: got y=%0d expected %0d", bus.y_ball, FIELD_H - BALL_R - SPD_INIT);
    end
  endtask

  task automatic test_paddle_right();
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      bus.bar_1_y = 10'(my);
      bus.bar_2_y = 10'(my);
      applyStimulus(1'b1, 1'b0);
      if (bus.x_ball == 10'(BAR2_X - BAR_HW - BALL_R)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL paddle_right: got no x=%0d within budget, required hit", BAR2_X - BAR_HW - BALL_R);
    end
    applyStimulus(1'b1, 1'b0);
    checks++;
    if (bus.x_ball !== 10'(BAR2_X - BAR_HW - BALL_R - SPD_HIT1)) begin
      errors++;
      $display("[TB] FAIL paddle_right_away: got x=%0d expected %0d", bus.x_ball, BAR2_X - BAR_HW - BALL_R - SPD_HIT1);
    end
  endtask

  task automatic test_paddle_left();
    bit found = 0;
    bit top_seen = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      bus.bar_1_y = 10'(my);
      bus.bar_2_y = 10'(my);
      applyStimulus(1'b1, 1'b0);
      if (bus.y_ball == 10'(BALL_R)) top_seen = 1;
      if (bus.x_ball == 10'(BAR1_X + BAR_HW + BALL_R)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL paddle_left: got no x=%0d within budget, required hit", BAR1_X + BAR_HW + BALL_R);
    end
    checks++;
    if (!top_seen) begin
      errors++;
      $display("[TB] FAIL wall_top: got no y=%0d on the way left, required bounce", BALL_R);
    end
    applyStimulus(1'b1, 1'b0);
    checks++;
    if (bus.x_ball !== 10'(BAR1_X + BAR_HW + BALL_R + SPD_HIT2)) begin
      errors++;
      $display("[TB] FAIL paddle_left_away: got x=%0d expected %0d", bus.x_ball, BAR1_X + BAR_HW + BALL_R + SPD_HIT2);
    end
  endtask

  task automatic test_point2();
    bit found = 0;
    bus.bar_1_y = 10'd1023;
    for (int i = 0; i < 1000 && !found; i++) begin
      bus.bar_2_y = 10'(my);
      applyStimulus(1'b1, 1'b0);
      if (bus.point2 === 1'b1) found = 1;
    end
    checks++;
    if (!found || {bus.point1, bus.serving} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL point2_pulse: got found=%0b p1=%b serving=%b expected 1 0 0", found, bus.point1, bus.serving);
    end
    applyStimulus(1'b0, 1'b0);
    checks++;
    if (bus.point2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL point2_width: got p2=%b expected 0 one cycle later", bus.point2);
    end
    applyStimulus(1'b1, 1'b0);
    checks++;
    if ({bus.serving, bus.x_ball, bus.y_ball} !== {1'b1, 10'd310, 10'd180}) begin
      errors++;
      $display("[TB] FAIL point2_recentre: got serving=%b (%0d,%0d) expected 1 (310,180)", bus.serving, bus.x_ball, bus.y_ball);
    end
    for (int i = 0; i < SERVE_TICKS + 1; i++) applyStimulus(1'b1, 1'b0);
    checks++;
    if (bus.x_ball !== 10'(310 + SPD_INIT)) begin
      errors++;
      $display("[TB] FAIL point2_serve_dir: got x=%0d expected %0d", bus.x_ball, 310 + SPD_INIT);
    end
  endtask

  task automatic test_point1();
    bit found = 0;
    bus.bar_2_y = 10'd1023;
    for (int i = 0; i < 1000 && !found; i++) begin
      bus.bar_1_y = 10'(my);
      applyStimulus(1'b1, 1'b0);
      if (bus.point1 === 1'b1) found = 1;
    end
    checks++;
    if (!found || {bus.point2, bus.serving} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL point1_pulse: got found=%0b p2=%b serving=%b expected 1 0 0", found, bus.point2, bus.serving);
    end
    for (int i = 0; i < SERVE_TICKS + 2; i++) applyStimulus(1'b1, 1'b0);
    checks++;
    if (bus.x_ball !== 10'(310 - SPD_INIT)) begin
      errors++;
      $display("[TB] FAIL point1_serve_dir: got x=%0d expected %0d", bus.x_ball, 310 - SPD_INIT);
    end
  endtask

  task automatic test_reset_abort();
    int budget = 0;
    bus.bar_1_y = 10'd1023;
    while (!(mstate == M_PLAY && mdx < 0 && mx - mspeed <= BALL_R) && budget < 1000) begin
      applyStimulus(1'b1, 1'b0);
      budget++;
    end
    checks++;
    if (budget >= 1000) begin
      errors++;
      $display("[TB] FAIL abort_setup: got no pre-miss position within budget, required one");
    end
    @(negedge mclk);
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.serving, bus.x_ball, bus.y_ball, bus.point1, bus.point2} !== {1'b1, 10'd310, 10'd180, 2'b00}) begin
      errors++;
      $display("[TB] FAIL abort_reset: got serving=%b (%0d,%0d) p=%b%b expected 1 (310,180) 00",
               bus.serving, bus.x_ball, bus.y_ball, bus.point1, bus.point2);
    end
    @(negedge mclk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checks++;
    if ({bus.point1, bus.point2} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL abort_no_point: got p1/p2=%b%b expected 00", bus.point1, bus.point2);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b1;
    bus.tick = 1'b0;
    bus.pause = 1'b0;
    bus.bar_1_y = 10'd180;
    bus.bar_2_y = 10'd180;
    model_reset();
    test_reset();
    test_serve();
    test_pause();
    test_wall();
    test_paddle_right();
    test_paddle_left();
    test_point2();
    test_point1();
    test_reset_abort();
    repeat (2) @(negedge mclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
